cr16_psr: RTL and testbench
===========================

CR16_PSR -- requirements
Module: cr16_psr

Interface
REQ-001 SHALL have parameter P_DEPTH, default 4, number of PSR save/restore stack entries; legal values are 2..8.
REQ-002 SHALL have port I_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port I_RESET  input  1  reset; reset is synchronous and active-high.
REQ-004 SHALL have port I_ENABLE  input  1  global advance; when low, all state holds.
REQ-005 SHALL have port I_STATUS  input  5  ALU status vector; bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N.
REQ-006 SHALL have port I_WRITE  input  1  capture masked I_STATUS into PSR.
REQ-007 SHALL have port I_MASK  input  5  per-flag write mask, same bit order as I_STATUS.
REQ-008 SHALL have port I_COND_REQ  input  1  request condition evaluation.
REQ-009 SHALL have port I_COND  input  4  CR16 condition code to evaluate.
REQ-010 SHALL have port I_PUSH / I_POP  input  1 each  save PSR to stack / restore PSR from stack.
REQ-011 SHALL have port I_CLR_ERR  input  1  clear sticky error flags.
REQ-012 SHALL have port O_PSR  output  5  current flag register.
REQ-013 SHALL have ports O_COND_VALID, O_COND_TRUE  output  1 each  evaluation result strobe and value.
REQ-014 SHALL have port O_DEPTH  output  4  stack occupancy, 0..P_DEPTH.
REQ-015 SHALL have ports O_FULL, O_EMPTY  output  1 each  occupancy == P_DEPTH / occupancy == 0.
REQ-016 SHALL have ports O_OVERFLOW, O_UNDERFLOW, O_ERR  output  1 each  sticky overflow, sticky underflow, and a one-cycle push+pop conflict pulse.

Function
REQ-017 With I_ENABLE high and I_WRITE high, the next PSR SHALL be (I_STATUS & I_MASK) | (PSR & ~I_MASK).
REQ-018 With I_PUSH high, not full, and I_POP low, the pre-update PSR SHALL be written to the stack top and occupancy SHALL increment; a write in the same cycle still applies to PSR.
REQ-019 With I_POP high, not empty, and I_PUSH low, PSR SHALL load the stack top and occupancy SHALL decrement; a write in the same cycle is discarded (pop wins).
REQ-020 A push when full SHALL leave the stack unchanged and set O_OVERFLOW; a simultaneous I_WRITE still applies.
REQ-021 A pop when empty SHALL leave the stack unchanged, set O_UNDERFLOW, and leave PSR unchanged; a simultaneous I_WRITE still applies.
REQ-022 I_PUSH and I_POP both high SHALL be a no-op on the stack, SHALL pulse O_ERR for one cycle, and SHALL let I_WRITE apply.
REQ-023 I_CLR_ERR SHALL clear O_OVERFLOW and O_UNDERFLOW; a new error in the same cycle wins (flag set).
REQ-024 I_COND_REQ SHALL produce O_COND_VALID=1 exactly one cycle later, with O_COND_TRUE evaluated against the next PSR value (after this cycle's write or pop, i.e. forwarded).
REQ-025 O_COND_VALID SHALL be 0 in any cycle not preceded by an enabled request; O_COND_TRUE SHALL hold its last value when O_COND_VALID is 0.
REQ-026 The condition table SHALL be:
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 HI: L
- 5 LS: !L
- 6 GT: N
- 7 LE: !N
- 8 FS: F
- 9 FC: !F
- 10 LO: !L&!Z
- 11 HS: L|Z
- 12 LT: !N&!Z
- 13 GE: N|Z
- 14 UC: 1
- 15 never: 0
REQ-027 With I_ENABLE low, all registers SHALL hold except O_COND_VALID and O_ERR, which SHALL be driven 0.
REQ-028 O_FULL, O_EMPTY, and O_DEPTH SHALL be registered-state derived with no combinational path from inputs.

Reset
REQ-029 I_RESET high at a clock edge SHALL, regardless of I_ENABLE or other inputs, set:
- O_PSR=0, O_DEPTH=0, O_EMPTY=1, O_FULL=0
- O_OVERFLOW=0, O_UNDERFLOW=0, O_ERR=0
- O_COND_VALID=0, O_COND_TRUE=0
REQ-030 Reset mid-operation SHALL discard all stack contents and any pending evaluation; stack RAM contents need not be cleared, but SHALL be unreadable until pushed.

Verification
REQ-031 Masked write: PSR=0, I_WRITE, I_STATUS=5'b11111, I_MASK=5'b01001 -> O_PSR=5'b01001 next cycle.
REQ-032 Forwarded condition: PSR=0, I_WRITE with Z set, plus I_COND_REQ with I_COND=0 in the same cycle -> next cycle O_COND_VALID=1, O_COND_TRUE=1; I_COND=12 in that cycle -> 0.
REQ-033 Stack nesting (P_DEPTH=4): push PSR values 1,2,3,4 -> O_FULL=1; a fifth push -> O_OVERFLOW=1, depth 4; four pops -> O_PSR sequence 4,3,2,1 and O_EMPTY=1.
REQ-034 Underflow/priority: pop when empty with I_WRITE of 5'b10000, mask all -> O_UNDERFLOW=1, O_PSR=5'b10000; a later pop+write with non-empty stack -> PSR equals the stack value.
REQ-035 Conflict and enable: push+pop together -> O_ERR high for one cycle, depth unchanged; I_ENABLE low with requests asserted -> no state change, O_COND_VALID=0.
REQ-036 Reset mid-stack: depth 3, assert I_RESET with I_PUSH high -> O_DEPTH=0, O_PSR=0, no flags set.

Source files
------------

// File: rtl/cr16_psr.sv
// cr16_psr -- CR16 processor status register with save/restore stack.
//
// Holds the five-flag PSR (bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N). It
// supports masked flag writes, a P_DEPTH-entry LIFO for saving and
// restoring the PSR, and registered evaluation of CR16 condition codes.
//
// Ports:
//   I_CLK, I_RESET          clock, synchronous active-high reset
//   I_ENABLE                global advance; low holds all state
//   I_STATUS, I_MASK        ALU flags and per-flag write mask
//   I_WRITE                 capture masked I_STATUS into the PSR
//   I_COND_REQ, I_COND      condition evaluation request and code
//   I_PUSH, I_POP           save PSR to stack / restore PSR from stack
//   I_CLR_ERR               clear sticky overflow/underflow
//   O_PSR                   current flags
//   O_COND_VALID/TRUE       evaluation strobe (one cycle after request) and result
//   O_DEPTH, O_FULL/EMPTY   stack occupancy and its limits
//   O_OVERFLOW/UNDERFLOW    sticky stack errors
//   O_ERR                   one-cycle pulse on a push+pop conflict
module cr16_psr #(
   parameter int P_DEPTH = 4
) (
   input  logic       I_CLK,
   input  logic       I_RESET,
   input  logic       I_ENABLE,
   input  logic [4:0] I_STATUS,
   input  logic       I_WRITE,
   input  logic [4:0] I_MASK,
   input  logic       I_COND_REQ,
   input  logic [3:0] I_COND,
   input  logic       I_PUSH,
   input  logic       I_POP,
   input  logic       I_CLR_ERR,
   output logic [4:0] O_PSR,
   output logic       O_COND_VALID,
   output logic       O_COND_TRUE,
   output logic [3:0] O_DEPTH,
   output logic       O_FULL,
   output logic       O_EMPTY,
   output logic       O_OVERFLOW,
   output logic       O_UNDERFLOW,
   output logic       O_ERR
);

   localparam int         AW        = (P_DEPTH <= 2) ? 1 : ((P_DEPTH <= 4) ? 2 : 3);
   localparam logic [3:0] DEPTH_MAX = 4'(P_DEPTH);

   // CR16 condition code evaluation against a flag vector.
   function automatic logic cond_eval(input logic [3:0] cc, input logic [4:0] f);
      logic c, l, fl, z, n;
      c  = f[0];
      l  = f[1];
      fl = f[2];
      z  = f[3];
      n  = f[4];
      case (cc)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return c;
         4'd3:    return !c;
         4'd4:    return l;
         4'd5:    return !l;
         4'd6:    return n;
         4'd7:    return !n;
         4'd8:    return fl;
         4'd9:    return !fl;
         4'd10:   return !l && !z;
         4'd11:   return l || z;
         4'd12:   return !n && !z;
         4'd13:   return n || z;
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   logic [4:0]    stack_mem [0:(1 << AW) - 1];
   logic [AW-1:0] push_idx;
   logic [AW-1:0] pop_idx;
   logic          push_ok;
   logic          pop_ok;
   logic          push_ovf;
   logic          pop_unf;
   logic [4:0]    psr_wr;
   logic [4:0]    psr_nxt;

   assign O_FULL  = (O_DEPTH == DEPTH_MAX);
   assign O_EMPTY = (O_DEPTH == 4'd0);

   assign push_idx = O_DEPTH[AW-1:0];
   assign pop_idx  = AW'(O_DEPTH - 4'd1);

   always_comb begin
      push_ok  = I_PUSH && !I_POP && !O_FULL;
      pop_ok   = I_POP && !I_PUSH && !O_EMPTY;
      push_ovf = I_PUSH && !I_POP && O_FULL;
      pop_unf  = I_POP && !I_PUSH && O_EMPTY;
      psr_wr   = I_WRITE ? ((I_STATUS & I_MASK) | (O_PSR & ~I_MASK)) : O_PSR;
      // A successful pop overrides any same-cycle write.
      psr_nxt  = pop_ok ? stack_mem[pop_idx] : psr_wr;
   end

   // Stack storage is not reset; occupancy alone decides what is readable.
   always_ff @(posedge I_CLK) begin
      if (!I_RESET && I_ENABLE && push_ok)
         stack_mem[push_idx] <= O_PSR;
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         O_PSR        <= 5'd0;
         O_DEPTH      <= 4'd0;
         O_OVERFLOW   <= 1'b0;
         O_UNDERFLOW  <= 1'b0;
         O_ERR        <= 1'b0;
         O_COND_VALID <= 1'b0;
         O_COND_TRUE  <= 1'b0;
      end else if (I_ENABLE) begin
         O_PSR <= psr_nxt;
         if (push_ok)
            O_DEPTH <= O_DEPTH + 4'd1;
         else if (pop_ok)
            O_DEPTH <= O_DEPTH - 4'd1;
         O_ERR        <= I_PUSH && I_POP;
         // Setting a sticky flag takes priority over clearing it.
         O_OVERFLOW   <= push_ovf || (O_OVERFLOW && !I_CLR_ERR);
         O_UNDERFLOW  <= pop_unf || (O_UNDERFLOW && !I_CLR_ERR);
         O_COND_VALID <= I_COND_REQ;
         if (I_COND_REQ)
            O_COND_TRUE <= cond_eval(I_COND, psr_nxt);
      end else begin
         O_COND_VALID <= 1'b0;
         O_ERR        <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cr16_psr.sv
// Testbench for cr16_psr: directed vector table followed by randomized
// stimulus checked against a queue-based reference model.
module tb_cr16_psr;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, en, wr, cq, push, pop, clr;
   logic [4:0] st, mk;
   logic [3:0] cc;
   logic [4:0] o_psr;
   logic       o_cv, o_ct, o_full, o_empty, o_ovf, o_unf, o_err;
   logic [3:0] o_depth;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cr16_psr #(.P_DEPTH(DEPTH)) dut (
      .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_STATUS(st), .I_WRITE(wr),
      .I_MASK(mk), .I_COND_REQ(cq), .I_COND(cc), .I_PUSH(push), .I_POP(pop),
      .I_CLR_ERR(clr), .O_PSR(o_psr), .O_COND_VALID(o_cv), .O_COND_TRUE(o_ct),
      .O_DEPTH(o_depth), .O_FULL(o_full), .O_EMPTY(o_empty),
      .O_OVERFLOW(o_ovf), .O_UNDERFLOW(o_unf), .O_ERR(o_err)
   );

   typedef struct {
      logic       rst, en, wr, cq, push, pop, clr;
      logic [4:0] st, mk;
      logic [3:0] cc;
      logic [4:0] e_psr;
      logic [3:0] e_depth;
      logic       e_cv, e_ct, e_ovf, e_unf, e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic e, input logic w,
                               input logic [4:0] s, input logic [4:0] m,
                               input logic q, input logic [3:0] c,
                               input logic pu, input logic po, input logic cl,
                               input logic [4:0] ep, input logic [3:0] ed,
                               input logic ecv, input logic ect,
                               input logic eo, input logic eu, input logic ee);
      vec_t v;
      v.rst = r; v.en = e; v.wr = w; v.st = s; v.mk = m; v.cq = q; v.cc = c;
      v.push = pu; v.pop = po; v.clr = cl;
      v.e_psr = ep; v.e_depth = ed; v.e_cv = ecv; v.e_ct = ect;
      v.e_ovf = eo; v.e_unf = eu; v.e_err = ee;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic w,
                        input logic [4:0] s, input logic [4:0] m,
                        input logic q, input logic [3:0] c,
                        input logic pu, input logic po, input logic cl);
      rst = r; en = e; wr = w; st = s; mk = m; cq = q; cc = c;
      push = pu; pop = po; clr = cl;
   endtask

   task automatic check_all(input string tag, input logic [4:0] ep, input logic [3:0] ed,
                            input logic ecv, input logic ect, input logic eo,
                            input logic eu, input logic ee);
      chk({tag, " psr"}, 8'(o_psr), 8'(ep));
      chk({tag, " depth"}, 8'(o_depth), 8'(ed));
      chk({tag, " full"}, 8'(o_full), 8'(ed == 4'(DEPTH)));
      chk({tag, " empty"}, 8'(o_empty), 8'(ed == 4'd0));
      chk({tag, " cond_valid"}, 8'(o_cv), 8'(ecv));
      chk({tag, " cond_true"}, 8'(o_ct), 8'(ect));
      chk({tag, " overflow"}, 8'(o_ovf), 8'(eo));
      chk({tag, " underflow"}, 8'(o_unf), 8'(eu));
      chk({tag, " err"}, 8'(o_err), 8'(ee));
   endtask

   // Reference condition evaluation, written from flag names.
   function automatic logic ref_cond(input int code, input int f);
      bit C, L, F, Z, N;
      C = f[0]; L = f[1]; F = f[2]; Z = f[3]; N = f[4];
      if (code == 14) return 1'b1;
      if (code == 15) return 1'b0;
      if (code == 10) return !L && !Z;
      if (code == 11) return L || Z;
      if (code == 12) return !N && !Z;
      if (code == 13) return N || Z;
      // Codes 0..9 come in true/complement pairs on a single flag.
      begin
         bit base;
         case (code / 2)
            0: base = Z;
            1: base = C;
            2: base = L;
            3: base = N;
            default: base = F;
         endcase
         return (code % 2 == 0) ? base : !base;
      end
   endfunction

   // Reference model state.
   int m_psr;
   int m_stack[$];
   bit m_ovf, m_unf, m_err, m_cv, m_ct;

   task automatic model_step();
      int nxt;
      if (rst) begin
         m_psr = 0; m_stack.delete();
         m_ovf = 0; m_unf = 0; m_err = 0; m_cv = 0; m_ct = 0;
      end else if (!en) begin
         m_cv = 0; m_err = 0;
      end else begin
         bit so, su;
         so = 0; su = 0;
         nxt = wr ? ((int'(st) & int'(mk)) | (m_psr & ~int'(mk) & 31)) : m_psr;
         m_err = push && pop;
         if (push && !pop) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_psr);
            else so = 1;
         end
         if (pop && !push) begin
            if (m_stack.size() > 0) nxt = m_stack.pop_back();
            else su = 1;
         end
         m_ovf = so || (m_ovf && !clr);
         m_unf = su || (m_unf && !clr);
         m_cv  = cq;
         if (cq) m_ct = ref_cond(int'(cc), nxt);
         m_psr = nxt;
      end
   endtask

   initial begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      //  rst en wr st     mk     cq cc  pu po cl   psr    dep cv ct ov un er
      add(1, 1, 0, 5'h00, 5'h00, 0, 0,  0, 0, 0,  5'h00, 0,  0, 0, 0, 0, 0); // reset
      add(0, 1, 1, 5'h1F, 5'h09, 0, 0,  0, 0, 0,  5'h09, 0,  0, 0, 0, 0, 0); // masked write
      add(0, 1, 1, 5'h00, 5'h1F, 0, 0,  0, 0, 0,  5'h00, 0,  0, 0, 0, 0, 0);
      add(0, 1, 1, 5'h08, 5'h1F, 1, 0,  0, 0, 0,  5'h08, 0,  1, 1, 0, 0, 0); // EQ forwarded
      add(0, 1, 1, 5'h08, 5'h1F, 1, 12, 0, 0, 0,  5'h08, 0,  1, 0, 0, 0, 0); // LT
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 0, 0,  5'h08, 0,  0, 0, 0, 0, 0);
      add(0, 1, 1, 5'h01, 5'h1F, 0, 0,  0, 0, 0,  5'h01, 0,  0, 0, 0, 0, 0);
      add(0, 1, 1, 5'h02, 5'h1F, 0, 0,  1, 0, 0,  5'h02, 1,  0, 0, 0, 0, 0); // push 1
      add(0, 1, 1, 5'h03, 5'h1F, 0, 0,  1, 0, 0,  5'h03, 2,  0, 0, 0, 0, 0); // push 2
      add(0, 1, 1, 5'h04, 5'h1F, 0, 0,  1, 0, 0,  5'h04, 3,  0, 0, 0, 0, 0); // push 3
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  1, 0, 0,  5'h04, 4,  0, 0, 0, 0, 0); // push 4 -> full
      add(0, 1, 1, 5'h05, 5'h1F, 0, 0,  1, 0, 0,  5'h05, 4,  0, 0, 1, 0, 0); // overflow, write applies
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 1, 0,  5'h04, 3,  0, 0, 1, 0, 0); // pop 4
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 1, 0,  5'h03, 2,  0, 0, 1, 0, 0);
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 1, 0,  5'h02, 1,  0, 0, 1, 0, 0);
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 1, 0,  5'h01, 0,  0, 0, 1, 0, 0); // empty
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 0, 1,  5'h01, 0,  0, 0, 0, 0, 0); // clear
      add(0, 1, 1, 5'h10, 5'h1F, 0, 0,  0, 1, 0,  5'h10, 0,  0, 0, 0, 1, 0); // underflow + write
      add(0, 1, 1, 5'h03, 5'h1F, 0, 0,  1, 0, 0,  5'h03, 1,  0, 0, 0, 1, 0); // push 10
      add(0, 1, 1, 5'h1F, 5'h1F, 1, 13, 0, 1, 0,  5'h10, 0,  1, 1, 0, 1, 0); // pop wins, GE fwd
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 1, 1,  5'h10, 0,  0, 1, 0, 1, 0); // new error beats clear
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 0, 1,  5'h10, 0,  0, 1, 0, 0, 0);
      add(0, 1, 1, 5'h07, 5'h03, 0, 0,  1, 1, 0,  5'h13, 0,  0, 1, 0, 0, 1); // conflict
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 0, 0,  5'h13, 0,  0, 1, 0, 0, 0); // err one cycle
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  1, 0, 0,  5'h13, 1,  0, 1, 0, 0, 0);
      add(0, 0, 1, 5'h00, 5'h1F, 1, 14, 1, 0, 1,  5'h13, 1,  0, 1, 0, 0, 0); // disabled
      add(0, 0, 0, 5'h00, 5'h00, 1, 15, 1, 1, 0,  5'h13, 1,  0, 1, 0, 0, 0); // disabled conflict
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  1, 0, 0,  5'h13, 2,  0, 1, 0, 0, 0);
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  1, 0, 0,  5'h13, 3,  0, 1, 0, 0, 0);
      add(1, 0, 1, 5'h1F, 5'h1F, 1, 14, 1, 0, 0,  5'h00, 0,  0, 0, 0, 0, 0); // reset mid-stack
      add(0, 1, 0, 5'h00, 5'h00, 1, 1,  0, 0, 0,  5'h00, 0,  1, 1, 0, 0, 0); // NE on zero psr
      add(0, 1, 0, 5'h00, 5'h00, 0, 0,  0, 1, 0,  5'h00, 0,  0, 1, 0, 1, 0); // stack discarded

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].wr, tbl[i].st, tbl[i].mk,
               tbl[i].cq, tbl[i].cc, tbl[i].push, tbl[i].pop, tbl[i].clr);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), tbl[i].e_psr, tbl[i].e_depth, tbl[i].e_cv,
                   tbl[i].e_ct, tbl[i].e_ovf, tbl[i].e_unf, tbl[i].e_err);
      end

      // Randomized run; first cycle is a reset so model and DUT align.
      for (int n = 0; n < 600; n++) begin
         if (n == 0)
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         else
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 2) == 0, 5'($urandom), 5'($urandom),
                  $urandom_range(0, 1) == 1, 4'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
         model_step();
         @(posedge clk);
         #1;
         check_all($sformatf("rnd%0d", n), 5'(m_psr), 4'(m_stack.size()), m_cv, m_ct,
                   m_ovf, m_unf, m_err);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
